// File: rtl/pkt_filter_pkg.sv
// Shared definitions for the packet dispatch filter: type codes, unit bit
// positions, broadcast ID, FSM states and the fixed per-type route mask.
package pkt_filter_pkg;

    localparam int NUM_UNITS = 4;

    localparam int U_QTU    = 0;
    localparam int U_MNI    = 1;
    localparam int U_KCH    = 2;
    localparam int U_REWARD = 3;

    localparam int unsigned PT_HEARTBEAT    = 0;
    localparam int unsigned PT_CH_ANNOUNCE  = 1;
    localparam int unsigned PT_CLUSTER_JOIN = 2;
    localparam int unsigned PT_DATA         = 3;
    localparam int unsigned PT_Q_UPDATE     = 4;

    // All-ones broadcast; users slice the low WORD_WIDTH bits.
    localparam logic [63:0] BCAST_ID = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2
    } state_e;

    function automatic logic [NUM_UNITS-1:0] route_mask(input int unsigned ptype,
                                                        input logic        dest_hit);
        logic [NUM_UNITS-1:0] m;
        m = '0;
        case (ptype)
            PT_HEARTBEAT: begin
                m[U_MNI]    = 1'b1;
                m[U_REWARD] = 1'b1;
            end
            PT_CH_ANNOUNCE: begin
                m[U_KCH] = 1'b1;
                m[U_QTU] = 1'b1;
            end
            PT_CLUSTER_JOIN: m[U_KCH] = dest_hit;
            PT_DATA: begin
                if (dest_hit) m[U_REWARD] = 1'b1;
                else          m[U_QTU]    = 1'b1;
            end
            PT_Q_UPDATE: m[U_QTU] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pkt_hdr_fifo.sv
// Small synchronous header FIFO with full/empty flags; a push is accepted
// while full when a pop happens in the same cycle.
module pkt_hdr_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // validity, and a resettable array costs a flop-per-bit reset network.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/pkt_dispatch_filter.sv
// Header queue + classifier + dispatch FSM for the EER-RL units.
// Optional WAIT-state watchdog enabled by defining PKTF_TIMEOUT_EN.
module pkt_dispatch_filter
    import pkt_filter_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter int TYPE_WIDTH     = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  newpkt,
    input  logic [TYPE_WIDTH-1:0] fPktType,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [3:0]            unit_done,
    output logic                  en_QTU,
    output logic                  en_MNI,
    output logic                  en_KCH,
    output logic                  en_reward,
    output logic                  iAmDestination,
    output logic                  busy,
    output logic                  fifo_full,
    output logic [7:0]            drop_cnt,
    output logic                  timeout_err
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pkt_dispatch_filter: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_e                r_state;
    logic [NUM_UNITS-1:0]  r_mask;
    logic [NUM_UNITS-1:0]  r_en;
    logic [NUM_UNITS-1:0]  r_collected;
    logic                  r_iam;
    logic                  r_busy;
    logic [7:0]            r_drop_cnt;

    logic                  w_hit;
    logic [TYPE_WIDTH:0]   w_wdata;
    logic [TYPE_WIDTH:0]   w_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [NUM_UNITS-1:0]  w_head_mask;
    logic [NUM_UNITS-1:0]  w_collect;
    logic                  w_complete;

    assign w_hit   = (destinationID == myNodeID) ||
                     (destinationID == BCAST_ID[WORD_WIDTH-1:0]);
    assign w_wdata = {fPktType, w_hit};
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_push  = newpkt && (!w_full || w_pop);
    assign w_drop  = newpkt && w_full && !w_pop;

    assign w_head_mask = route_mask(32'(w_rdata[TYPE_WIDTH:1]), w_rdata[0]);
    assign w_collect   = r_collected | unit_done;
    assign w_complete  = ((w_collect & r_mask) == r_mask);

    pkt_hdr_fifo #(
        .WIDTH (TYPE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef PKTF_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout_err;
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_en        <= '0;
            r_collected <= '0;
            r_iam       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PKTF_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_en <= '0;
            case (r_state)
                ST_IDLE: begin
                    // Zero-mask entries are popped and dropped here, one per cycle.
                    if (!w_empty && w_head_mask != '0) begin
                        r_mask  <= w_head_mask;
                        r_en    <= w_head_mask;
                        r_iam   <= w_rdata[0];
                        r_busy  <= 1'b1;
                        r_state <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    r_collected <= unit_done;
                    r_state     <= ST_WAIT;
`ifdef PKTF_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                end
                ST_WAIT: begin
                    r_collected <= w_collect;
                    if (w_complete) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_iam   <= 1'b0;
                    end
`ifdef PKTF_TIMEOUT_EN
                    else if (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_iam         <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign en_QTU         = r_en[U_QTU];
    assign en_MNI         = r_en[U_MNI];
    assign en_KCH         = r_en[U_KCH];
    assign en_reward      = r_en[U_REWARD];
    assign iAmDestination = r_iam;
    assign busy           = r_busy;
    assign fifo_full      = w_full;
    assign drop_cnt       = r_drop_cnt;
`ifdef PKTF_TIMEOUT_EN
    assign timeout_err    = r_timeout_err;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_dispatch_filter.sv
// Scoreboard bench for pkt_dispatch_filter; the timeout section follows
// PKTF_TIMEOUT_EN so the same file covers both builds.
module tb_pkt_dispatch_filter;

    localparam int WW = 16;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          newpkt = 1'b0;
    logic [TW-1:0] fPktType = '0;
    logic [WW-1:0] destinationID = '0;
    logic [WW-1:0] myNodeID = 16'h000C;
    logic [3:0]    unit_done = '0;
    logic          en_QTU, en_MNI, en_KCH, en_reward;
    logic          iAmDestination, busy, fifo_full, timeout_err;
    logic [7:0]    drop_cnt;
    logic [3:0]    en_vec;

    assign en_vec = {en_reward, en_KCH, en_MNI, en_QTU};

    pkt_dispatch_filter #(
        .WORD_WIDTH     (WW),
        .TYPE_WIDTH     (TW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .newpkt         (newpkt),
        .fPktType       (fPktType),
        .destinationID  (destinationID),
        .myNodeID       (myNodeID),
        .unit_done      (unit_done),
        .en_QTU         (en_QTU),
        .en_MNI         (en_MNI),
        .en_KCH         (en_KCH),
        .en_reward      (en_reward),
        .iAmDestination (iAmDestination),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .drop_cnt       (drop_cnt),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mask;
        logic       iam;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_mode = 0;   // 0 withhold, 1 in DISPATCH, 2 late + stray bits, 3 hold all high
    int         cyc = 0;
    int         last_disp = -100;
    logic [3:0] prev_en = '0;
    logic [3:0] resp_mask = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected route mask, bit order {reward, KCH, MNI, QTU}.
    function automatic logic [3:0] model_mask(input logic [2:0] t, input logic hit);
        case (t)
            3'b000:  return 4'b1010;
            3'b001:  return 4'b0101;
            3'b010:  return hit ? 4'b0100 : 4'b0000;
            3'b011:  return hit ? 4'b1000 : 4'b0001;
            3'b100:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] d, input logic exp_drop);
        logic       hit;
        logic [3:0] m;
        hit = (d == myNodeID) || (d == 16'hFFFF);
        m   = model_mask(t, hit);
        if (!exp_drop && m != 4'b0000) sb_q.push_back('{mask: m, iam: hit});
        newpkt        = 1'b1;
        fPktType      = t;
        destinationID = d;
        tick();
        newpkt = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) check({tag, "_wait_expired"}, 1, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, en_vec, 0);
        check({tag, "_iam"}, iAmDestination, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_full"}, fifo_full, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_tout"}, timeout_err, 0);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every enable pulse consumes one expected dispatch.
    always @(negedge clk) begin
        if (en_vec != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_en", en_vec, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("en_mask", en_vec, e.mask);
                check("en_iam", iAmDestination, e.iam);
            end
            check("en_one_cycle", prev_en, 0);
            check("disp_gap_ge3", (cyc - last_disp) >= 3, 1);
            last_disp = cyc;
        end
        prev_en = en_vec;
    end

    // Downstream unit model.
    always @(negedge clk) begin
        if (done_mode == 3) begin
            unit_done = 4'hF;
        end else if (en_vec != 4'b0000 && done_mode == 1) begin
            unit_done = en_vec;
        end else if (en_vec != 4'b0000 && done_mode == 2) begin
            resp_mask = en_vec;
            unit_done = ~resp_mask;
            @(negedge clk);
            unit_done = resp_mask;
        end else begin
            unit_done = '0;
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        nrst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Heartbeat: late completion with stray done bits outside the mask
        done_mode = 2;
        send(3'b000, 16'h0000, 1'b0);
        check("hb_en_capture_cycle", en_vec, 4'b0000);
        tick();
        check("hb_en_latency", en_vec, 4'b1010);
        check("hb_iam", iAmDestination, 0);
        tick();
        check("hb_en_fall", en_vec, 4'b0000);
        check("hb_busy_wait", busy, 1);
        tick();
        check("hb_busy_done", busy, 0);

        // Data to self, data elsewhere, broadcast, mixed types, capture-time node ID
        done_mode = 1;
        send(3'b011, 16'h000C, 1'b0);
        wait_idle("data_self", 20);
        send(3'b011, 16'h0005, 1'b0);
        wait_idle("data_other", 20);
        send(3'b011, 16'hFFFF, 1'b0);
        send(3'b001, 16'h0005, 1'b0);
        send(3'b010, 16'h000C, 1'b0);
        send(3'b100, 16'h000C, 1'b0);
        myNodeID = 16'h0021;
        send(3'b011, 16'h0021, 1'b0);
        myNodeID = 16'h000C;
        wait_idle("mixed", 60);

        // Filtered types
        send(3'b111, 16'h0007, 1'b0);
        check("filt_busy0", busy, 0);
        send(3'b101, 16'h0007, 1'b0);
        check("filt_busy1", busy, 0);
        send(3'b010, 16'h0007, 1'b0);
        check("filt_busy2", busy, 0);
        tick();
        check("filt_busy3", busy, 0);
        tick();
        check("filt_busy4", busy, 0);
        check("filt_drop", drop_cnt, 0);
        check("filt_full", fifo_full, 0);

        // Overflow: one in flight, four queued, sixth dropped
        done_mode = 0;
        for (int i = 0; i < 6; i++) send(3'b000, 16'h0000, i == 5);
        check("ovf_full", fifo_full, 1);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_busy", busy, 1);
        // Release the unit; the next IDLE pop coincides with a push into the full queue
        done_mode = 3;
        tick();
        check("ovf_full_before_pushpop", fifo_full, 1);
        send(3'b000, 16'h0000, 1'b0);
        check("pushpop_drop", drop_cnt, 1);
        wait_idle("ovf_drain", 100);
        check("ovf_full_after", fifo_full, 0);

        // Drop counter saturation
        done_mode = 0;
        tick();
        for (int i = 0; i < 260; i++) send(3'b000, 16'h0000, i >= 5);
        check("drop_sat", drop_cnt, 8'hFF);
        done_mode = 3;
        wait_idle("sat_drain", 100);
        check("drop_sat_hold", drop_cnt, 8'hFF);
        done_mode = 1;
        tick();

        // Completion timeout
        done_mode = 0;
        tick();
        send(3'b100, 16'h0005, 1'b0);
`ifdef PKTF_TIMEOUT_EN
        repeat (9) tick();
        check("tout_busy_last_wait", busy, 1);
        check("tout_err_before", timeout_err, 0);
        tick();
        check("tout_busy_idle", busy, 0);
        check("tout_err_set", timeout_err, 1);
        done_mode = 1;
        tick();
        send(3'b000, 16'h0000, 1'b0);
        wait_idle("tout_after", 20);
        check("tout_err_sticky", timeout_err, 1);
`else
        repeat (20) tick();
        check("notout_busy", busy, 1);
        check("notout_err", timeout_err, 0);
        done_mode = 3;
        wait_idle("notout_release", 20);
        done_mode = 1;
        tick();
`endif

        // Mid-wait asynchronous reset with two entries queued
        done_mode = 0;
        tick();
        for (int i = 0; i < 3; i++) send(3'b000, 16'h0000, 1'b0);
        tick();
        check("rst_busy_before", busy, 1);
        #2;
        nrst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sb_q.delete();
        tick();
        nrst = 1'b0;
        done_mode = 1;
        repeat (10) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_full", fifo_full, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d, expected 0", 1);
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/pkt_dispatch_filter.md
# pkt_dispatch_filter

Parametrised successor to the packet filter. Captures each received packet header into a small FIFO, classifies it by type and destination, and issues one-cycle enables to the downstream units (Q-table update, member-node info, known-cluster-head, reward). It then waits for those units to report completion before dispatching the next packet. It sits between the packet deframer and the EER-RL learning and cluster units.

## Interface
Parameters:
- WORD_WIDTH, 16: node ID width.
- TYPE_WIDTH, 3: packet type field width.
- FIFO_DEPTH, 4: header queue depth; power of two, ≥2.
- TIMEOUT_CYCLES, 64: WAIT-state limit; used only with the timeout feature.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  reset; asynchronous, active-high (1 = reset).
- newpkt  input  1  one-cycle strobe; header fields are valid in the same cycle.
- fPktType  input  TYPE_WIDTH  packet type.
- destinationID  input  WORD_WIDTH  packet destination.
- myNodeID  input  WORD_WIDTH  this node's ID.
- unit_done  input  4  completion strobes, bit order {reward, KCH, MNI, QTU}.
- en_QTU, en_MNI, en_KCH, en_reward  output  1 each  dispatch enables.
- iAmDestination  output  1  destination flag of the current packet.
- busy  output  1  FSM not in IDLE.
- fifo_full  output  1  queue full.
- drop_cnt  output  8  overflow drop count.
- timeout_err  output  1  sticky flag: a completion wait timed out.

## Operation
- On capture, each FIFO entry stores {type, dest_hit}.
  - dest_hit = (destinationID == myNodeID) || (destinationID == all-ones broadcast).
  - myNodeID is sampled at capture time.
- Route mask, indexed by type. Fixed values, defined in the package:
  - 000 heartbeat: MNI | reward.
  - 001 CH announce: KCH | QTU.
  - 010 cluster join: KCH if dest_hit, otherwise 0.
  - 011 data: reward if dest_hit, otherwise QTU.
  - 100 Q-update: QTU.
  - 101, 110, 111: 0.
- FSM has three states: IDLE, DISPATCH, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head entry. If its mask is 0, stay in IDLE and discard the entry (one entry per cycle). Otherwise load the mask and go to DISPATCH.
  - DISPATCH, one cycle: the enables selected by the mask are high. Done bits start collecting into a sticky register. Go to WAIT.
  - WAIT: keep collecting done bits. Return to IDLE once (collected & mask) == mask.
- Done bits for units outside the mask are ignored.
- A done strobe that arrives in the DISPATCH cycle counts toward completion.
- iAmDestination:
  - Loaded from dest_hit when the FSM enters DISPATCH.
  - Held through WAIT.
  - Cleared on return to IDLE.
- FIFO write while full with no pop in the same cycle: the packet is discarded and drop_cnt increments, saturating at 255.
- FIFO full, with newpkt and a pop in the same cycle: the write succeeds.

## Timing
- Reset values:
  - All enables 0.
  - iAmDestination 0.
  - busy 0.
  - fifo_full 0.
  - drop_cnt 0.
  - timeout_err 0.
  - FSM in IDLE.
  - FIFO empty.
- newpkt is sampled at edge N, and the entry is written at N.
- Edge N+1: IDLE pops the entry and the FSM moves to DISPATCH. The enables are high from N+1 to N+2. Minimum latency from capture to enable is therefore 1 cycle.
- Every enable is a registered pulse exactly one cycle wide.
- Minimum dispatch period is 3 cycles (DISPATCH, WAIT, IDLE).
- Reset asserted mid-operation: the FIFO is flushed, counters are cleared, and the FSM returns to IDLE asynchronously. The in-flight packet is lost.

## Configuration
- Macro: PKTF_TIMEOUT_EN.
- With PKTF_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If completion is still missing after TIMEOUT_CYCLES WAIT cycles, the FSM goes to IDLE and timeout_err is set.
  - timeout_err is sticky until reset.
- Without PKTF_TIMEOUT_EN:
  - WAIT has no time limit.
  - timeout_err is tied to 0.
  - There is no counter logic.

## Structure
- Package pkt_filter_pkg contains:
  - Packet type codes.
  - Unit bit indices.
  - Broadcast ID constant.
  - FSM state enum.
  - route_mask(type, dest_hit) function.
- Sub-module pkt_hdr_fifo: synchronous FIFO of width TYPE_WIDTH+1 and depth FIFO_DEPTH, with full and empty flags. It supports simultaneous push and pop.

## Test plan
- Heartbeat:
  - Stimulus: myNodeID = 0x000C, destinationID = 0x0000, fPktType = 000, newpkt for 1 cycle; unit_done = 4'b1010 two cycles later.
  - Response: en_MNI and en_reward pulse for exactly 1 cycle, 1 cycle after capture; iAmDestination = 0; busy falls after done.
- Data to self, then data to another node:
  - Stimulus: type 011 with dest 0x000C, then type 011 with dest 0x0005.
  - Response: first packet gives en_reward with iAmDestination = 1; second gives en_QTU only with iAmDestination = 0.
- Filtered types:
  - Stimulus: types 111, 101, and 010 with dest 0x0007, back to back.
  - Response: no enables; busy stays 0; drop_cnt = 0.
- Overflow:
  - Stimulus: withhold unit_done and send 6 heartbeats.
  - Response: 1 packet in dispatch, 4 queued; fifo_full = 1; drop_cnt = 1.
- Timeout (PKTF_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8):
  - Stimulus: type 100, unit_done held at 0.
  - Response: FSM is back in IDLE 8 WAIT cycles after DISPATCH; timeout_err = 1.
- Mid-wait reset:
  - Stimulus: assert nrst = 1 during WAIT with 2 entries queued.
  - Response: all outputs 0 immediately; no enables after nrst is released.
